// File: rtl/dadda_multiplier_24bit_pipelined.sv
// Unsigned 24x24 -> 48-bit multiplier: Dadda reduction tree plus Kogge-Stone final adder, two register stages.
// Define DADDA_MULT_INPUT_REG_EN to register in1/in2 first (latency 3 instead of 2).
module dadda_multiplier_24bit_pipelined (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] in1,
  input  logic [23:0] in2,
  output logic [47:0] out
);

  localparam int W       = 24;
  localparam int PW      = 2 * W;
  localparam int S1_ROWS = 6;

  typedef int hts_t [PW];

  // Bit matrix: bits[c][k] is the k-th bit of weight c; only k < h[c] is occupied.
  typedef struct {
    logic [W-1:0] bits [PW];
    hts_t         h;
  } mat_t;

  typedef logic [S1_ROWS-1:0][PW-1:0] rows6_t;

  function automatic mat_t pp_matrix(input logic [W-1:0] a, input logic [W-1:0] b);
    mat_t m;
    for (int c = 0; c < PW; c++) begin
      m.bits[c] = '0;
      m.h[c]    = 0;
    end
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        m.bits[i+j][m.h[i+j]] = a[j] & b[i];
        m.h[i+j]              = m.h[i+j] + 1;
      end
    end
    return m;
  endfunction

  // One Dadda level: the fewest full/half adders that bring every column to at most target bits.
  function automatic mat_t reduce_level(input mat_t m, input int target);
    mat_t r;
    int   pos [PW];
    int   ncin;
    int   hc;
    int   nfa;
    int   nha;
    int   idx;
    logic x, y, z;
    for (int c = 0; c < PW; c++) begin
      r.bits[c] = '0;
      pos[c]    = 0;
    end
    ncin = 0;
    for (int c = 0; c < PW; c++) begin
      // Carries already dropped into this column count toward its height.
      hc  = m.h[c] + ncin;
      nfa = 0;
      nha = 0;
      if (hc > target) begin
        nfa = (hc - target) / 2;
        nha = (hc - target) % 2;
      end
      idx = 0;
      for (int f = 0; f < W / 2; f++) begin
        if (f < nfa) begin
          x = m.bits[c][idx];
          y = m.bits[c][idx+1];
          z = m.bits[c][idx+2];
          r.bits[c][pos[c]] = x ^ y ^ z;
          pos[c]            = pos[c] + 1;
          if (c < PW - 1) begin
            r.bits[c+1][pos[c+1]] = (x & y) | (x & z) | (y & z);
            pos[c+1]              = pos[c+1] + 1;
          end
          idx = idx + 3;
        end
      end
      if (nha != 0) begin
        x = m.bits[c][idx];
        y = m.bits[c][idx+1];
        r.bits[c][pos[c]] = x ^ y;
        pos[c]            = pos[c] + 1;
        if (c < PW - 1) begin
          r.bits[c+1][pos[c+1]] = x & y;
          pos[c+1]              = pos[c+1] + 1;
        end
        idx = idx + 2;
      end
      for (int k = 0; k < W; k++) begin
        if (k >= idx && k < m.h[c]) begin
          r.bits[c][pos[c]] = m.bits[c][k];
          pos[c]            = pos[c] + 1;
        end
      end
      ncin = nfa + nha;
    end
    for (int c = 0; c < PW; c++) r.h[c] = pos[c];
    return r;
  endfunction

  function automatic mat_t stage1_reduce(input logic [W-1:0] a, input logic [W-1:0] b);
    mat_t m;
    m = pp_matrix(a, b);
    m = reduce_level(m, 19);
    m = reduce_level(m, 13);
    m = reduce_level(m, 9);
    m = reduce_level(m, 6);
    return m;
  endfunction

  function automatic rows6_t stage1_rows(input logic [W-1:0] a, input logic [W-1:0] b);
    mat_t   m;
    rows6_t rows;
    m = stage1_reduce(a, b);
    for (int c = 0; c < PW; c++) begin
      for (int r = 0; r < S1_ROWS; r++) rows[r][c] = m.bits[c][r];
    end
    return rows;
  endfunction

  // Column heights after stage 1 depend only on the tree shape, never on operand values.
  function automatic hts_t stage1_heights();
    mat_t m;
    m = stage1_reduce('0, '0);
    return m.h;
  endfunction

  function automatic logic [PW-1:0] ks_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW-1:0] g_n;
    logic [PW-1:0] p_n;
    g = a & b;
    p = a ^ b;
    for (int d = 1; d < PW; d = d * 2) begin
      g_n = g;
      p_n = p;
      for (int i = d; i < PW; i++) begin
        g_n[i] = g[i] | (p[i] & g[i-d]);
        p_n[i] = p[i] & p[i-d];
      end
      g = g_n;
      p = p_n;
    end
    // Carry-in is 0; the carry out of bit 47 is always 0 for a 24x24 product and is dropped.
    return (a ^ b) ^ {g[PW-2:0], 1'b0};
  endfunction

  function automatic logic [PW-1:0] stage2_sum(input rows6_t rows, input hts_t h);
    mat_t          m;
    logic [PW-1:0] a;
    logic [PW-1:0] b;
    for (int c = 0; c < PW; c++) begin
      m.h[c]    = h[c];
      m.bits[c] = '0;
      for (int r = 0; r < S1_ROWS; r++) begin
        if (r < h[c]) m.bits[c][r] = rows[r][c];
      end
    end
    m = reduce_level(m, 4);
    m = reduce_level(m, 3);
    m = reduce_level(m, 2);
    for (int c = 0; c < PW; c++) begin
      a[c] = m.bits[c][0];
      b[c] = m.bits[c][1];
    end
    return ks_add(a, b);
  endfunction

  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  rows6_t        s1_d;
  rows6_t        s1_q;
  hts_t          s1_h;
  logic [PW-1:0] s2_d;

`ifdef DADDA_MULT_INPUT_REG_EN
  logic [W-1:0] in1_q;
  logic [W-1:0] in2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in1_q <= '0;
      in2_q <= '0;
    end else begin
      in1_q <= in1;
      in2_q <= in2;
    end
  end

  assign op_a = in1_q;
  assign op_b = in2_q;
`else
  assign op_a = in1;
  assign op_b = in2;
`endif

  always_comb s1_d = stage1_rows(op_a, op_b);
  always_comb s1_h = stage1_heights();
  always_comb s2_d = stage2_sum(s1_q, s1_h);

  // NOTE: every pipeline register is cleared on reset so no stale product survives it;
  // non-blocking assignments make both stages sample their inputs from the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      out  <= '0;
    end else begin
      s1_q <= s1_d;
      out  <= s2_d;
    end
  end

endmodule

// File: tb/tb_dadda_multiplier_24bit_pipelined.sv
// Self-checking bench for dadda_multiplier_24bit_pipelined: constant vectors, reset sequences
// and random operands compared against a plain-arithmetic product history.
module tb_dadda_multiplier_24bit_pipelined;

`ifdef DADDA_MULT_INPUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] in1 = '0;
  logic [23:0] in2 = '0;
  logic [47:0] out;

  always #5 clk = ~clk;

  dadda_multiplier_24bit_pipelined dut (
    .clk (clk),
    .rst (rst),
    .in1 (in1),
    .in2 (in2),
    .out (out)
  );

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [47:0] hist[$];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: out=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
    return 48'(a) * 48'(b);
  endfunction

  // Drive one pair, clock it in, then compare out with the product sampled LAT-1 edges earlier.
  task automatic apply(input logic [23:0] a, input logic [23:0] b);
    logic [47:0] exp;
    in1 = a;
    in2 = b;
    @(posedge clk);
    hist.push_back(ref_mul(a, b));
    if (hist.size() > 8) void'(hist.pop_front());
    #1;
    exp = (hist.size() >= LAT) ? hist[hist.size() - LAT] : 48'h0;
    check("model", out, exp);
  endtask

  function automatic logic [23:0] rand_operand();
    logic [23:0] v;
    v = 24'($urandom);
    if ($urandom_range(0, 7) == 0) v = ($urandom_range(0, 1) == 0) ? 24'h000000 : 24'hFFFFFF;
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    tbl[0] = '{24'h800000, 24'h800000, 48'h400000000000};
    tbl[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    tbl[2] = '{24'hFFFFFF, 24'h000001, 48'h000000FFFFFF};
    tbl[3] = '{24'hABCDEF, 24'h000000, 48'h000000000000};
    tbl[4] = '{24'h000000, 24'hFFFFFF, 48'h000000000000};
    tbl[5] = '{24'h000003, 24'h000005, 48'h00000000000F};
    tbl[6] = '{24'h123456, 24'h654321, 48'h07336BF94116};
    tbl[7] = '{24'hABCDEF, 24'h000002, 48'h00000157_9BDE};
    tbl[8] = '{24'h000001, 24'h800000, 48'h000000800000};

    // Asynchronous reset asserted between clock edges.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("reset_immediate", out, 48'h0);
    in1 = 24'hFFFFFF;
    in2 = 24'hFFFFFF;
    repeat (3) @(posedge clk);
    #1 check("reset_held", out, 48'h0);
    #2 rst = 1'b0;
    hist.delete();

    // Constant vectors streamed back to back.
    for (int i = 0; i < 9 + LAT - 1; i++) begin
      if (i < 9) apply(tbl[i].a, tbl[i].b);
      else       apply(24'h0, 24'h0);
      if (i >= LAT - 1) check("table", out, tbl[i - LAT + 1].exp);
    end

    // Reset mid-stream after the second pair: no pre-reset product may reappear.
    apply(24'h000003, 24'h000005);
    apply(24'h123456, 24'h654321);
    #2 rst = 1'b1;
    #1 check("midreset_immediate", out, 48'h0);
    @(posedge clk);
    #1 check("midreset_held", out, 48'h0);
    #2 rst = 1'b0;
    hist.delete();
    for (int i = 0; i < LAT; i++) begin
      apply(24'h0, 24'h0);
      check("post_reset_zero", out, 48'h0);
    end
    apply(24'hABCDEF, 24'h000002);
    for (int i = 0; i < LAT - 1; i++) begin
      check("post_reset_latency", out, 48'h0);
      apply(24'h0, 24'h0);
    end
    check("post_reset_product", out, 48'h00000157_9BDE);

    // Random operands, one new pair every cycle.
    for (int i = 0; i < 20000; i++) apply(rand_operand(), rand_operand());
    for (int i = 0; i < LAT; i++) apply(24'h0, 24'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
